// File: rtl/dispatch_queue_pkg.sv
// rtl/dispatch_queue_pkg.sv - shared types and constants for the dispatch queue
package dispatch_queue_pkg;

  // Reorder buffer size shared with the ROB; sets the width of ROB entry tags
  localparam int ROB_ENTRIES = 32;

  // Default dispatch queue depth
  localparam int DQ_DEPTH_DEFAULT = 8;

  // Decoded instruction payload carried from decode to issue
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest_reg;
    logic        wb_en;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_queue_stats.sv
// rtl/dispatch_queue_stats.sv - saturating dispatch and ROB-stall event counters
module dispatch_queue_stats #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] i_acc_cnt,
  input  logic             i_stall,
  output logic [31:0]      o_dispatched,
  output logic [31:0]      o_rob_stall
);

  logic [31:0] r_dispatched;
  logic [31:0] r_rob_stall;
  logic [32:0] w_disp_sum;

  // Widened sum so a carry out signals that the counter would overflow
  always_comb begin
    w_disp_sum = {1'b0, r_dispatched} + 33'(i_acc_cnt);
  end

  // Both counters stick at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dispatched <= '0;
      r_rob_stall  <= '0;
    end else begin
      r_dispatched <= w_disp_sum[32] ? '1 : w_disp_sum[31:0];
      if (i_stall && (r_rob_stall != '1)) begin
        r_rob_stall <= r_rob_stall + 32'd1;
      end
    end
  end

  assign o_dispatched = r_dispatched;
  assign o_rob_stall  = r_rob_stall;

endmodule

// File: rtl/dispatch_queue.sv
// rtl/dispatch_queue.sv - multi-lane decode-to-ROB dispatch queue; DISPATCH_QUEUE_STATS_EN adds event counters
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int FIRE_WIDTH   = 2,
  parameter int DQ_DEPTH     = DQ_DEPTH_DEFAULT,
  parameter int ROB_IDX_W    = $clog2(ROB_ENTRIES)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush_en,
  input  logic [DECODE_WIDTH-1:0]                dec_valid,
  input  dispatch_entry_t [DECODE_WIDTH-1:0]     dec_entry,
  output logic                                   dec_ready,
  output logic [FIRE_WIDTH-1:0]                  fire_valid,
  output logic [FIRE_WIDTH-1:0][4:0]             fire_dest_reg,
  output logic [FIRE_WIDTH-1:0]                  fire_wb_en,
  input  logic [FIRE_WIDTH-1:0]                  rob_full,
  input  logic [FIRE_WIDTH-1:0][ROB_IDX_W-1:0]   rob_entry_idx,
  output logic [FIRE_WIDTH-1:0]                  iss_valid,
  output dispatch_entry_t [FIRE_WIDTH-1:0]       iss_entry,
  output logic [FIRE_WIDTH-1:0][ROB_IDX_W-1:0]   iss_rob_idx
`ifdef DISPATCH_QUEUE_STATS_EN
  ,
  output logic [31:0]                            stat_dispatched,
  output logic [31:0]                            stat_rob_stall
`endif
);

  localparam int IDX_W = $clog2(DQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  dispatch_entry_t  r_mem [DQ_DEPTH];

  logic [FIRE_WIDTH-1:0]                r_iss_valid;
  dispatch_entry_t [FIRE_WIDTH-1:0]     r_iss_entry;
  logic [FIRE_WIDTH-1:0][ROB_IDX_W-1:0] r_iss_rob_idx;

  logic [PTR_W-1:0]                   w_count;
  logic [PTR_W-1:0]                   w_free;
  logic                               w_enq;
  logic [PTR_W-1:0]                   w_enq_cnt;
  logic [DECODE_WIDTH-1:0][IDX_W-1:0] w_wr_idx;
  dispatch_entry_t [FIRE_WIDTH-1:0]   w_fire_entry;
  logic [FIRE_WIDTH-1:0]              w_accept;
  logic [PTR_W-1:0]                   w_acc_cnt;

  // Enqueue side: space check uses start-of-cycle occupancy only, so popped slots are not reused this cycle
  always_comb begin
    w_count   = r_tail - r_head;
    w_free    = PTR_W'(DQ_DEPTH) - w_count;
    dec_ready = !flush_en && (w_free >= PTR_W'(DECODE_WIDTH));
    w_enq     = dec_valid[0] && dec_ready;
    w_enq_cnt = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      w_wr_idx[i] = IDX_W'(r_tail + PTR_W'(i));
      if (w_enq && dec_valid[i]) begin
        w_enq_cnt = w_enq_cnt + PTR_W'(1);
      end
    end
  end

  // Fire side: oldest entries in program order; ROB acceptance is a contiguous prefix
  always_comb begin
    logic v_chain;
    v_chain   = 1'b1;
    w_acc_cnt = '0;
    for (int i = 0; i < FIRE_WIDTH; i++) begin
      w_fire_entry[i]  = r_mem[IDX_W'(r_head + PTR_W'(i))];
      fire_valid[i]    = (w_count > PTR_W'(i)) && !flush_en;
      fire_dest_reg[i] = w_fire_entry[i].dest_reg;
      fire_wb_en[i]    = w_fire_entry[i].wb_en;
      w_accept[i]      = v_chain && fire_valid[i] && !rob_full[i];
      v_chain          = w_accept[i];
      if (w_accept[i]) begin
        w_acc_cnt = w_acc_cnt + PTR_W'(1);
      end
    end
  end

  // Head/tail advance; flush empties the queue without touching storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_en) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + w_acc_cnt;
      r_tail <= r_tail + w_enq_cnt;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers alone
  always_ff @(posedge clk) begin
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      if (w_enq && dec_valid[i]) begin
        r_mem[w_wr_idx[i]] <= dec_entry[i];
      end
    end
  end

  // Issue register: accepted lanes leave one cycle later tagged with their ROB index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_valid   <= '0;
      r_iss_entry   <= '0;
      r_iss_rob_idx <= '0;
    end else if (flush_en) begin
      r_iss_valid <= '0;
    end else begin
      r_iss_valid <= w_accept;
      for (int i = 0; i < FIRE_WIDTH; i++) begin
        if (w_accept[i]) begin
          r_iss_entry[i]   <= w_fire_entry[i];
          r_iss_rob_idx[i] <= rob_entry_idx[i];
        end
      end
    end
  end

  assign iss_valid   = r_iss_valid;
  assign iss_entry   = r_iss_entry;
  assign iss_rob_idx = r_iss_rob_idx;

  // Decode lanes must be filled contiguously starting at lane 0
  assert property (@(posedge clk) disable iff (!rst_n)
    ((dec_valid & (dec_valid + DECODE_WIDTH'(1))) == '0));

`ifdef DISPATCH_QUEUE_STATS_EN
  dispatch_queue_stats #(
    .CNT_W (PTR_W)
  ) u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_acc_cnt    (w_acc_cnt),
    .i_stall      (fire_valid[0] && rob_full[0]),
    .o_dispatched (stat_dispatched),
    .o_rob_stall  (stat_rob_stall)
  );
`endif

endmodule
